// File: rtl/mem_arbiter_if.sv
// Host-side and RAM-side bus bundle for mem_arbiter.
// slave: arbiter view; master: hosts plus RAM view.
interface mem_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic                 d_req_i;
  logic                 d_we_i;
  logic [AddrWidth-1:0] d_addr_i;
  logic [DataWidth-1:0] d_wdata_i;
  logic                 d_gnt_o;
  logic                 d_rvalid_o;
  logic                 d_err_o;
  logic [DataWidth-1:0] d_rdata_o;

  logic                 i_req_i;
  logic [AddrWidth-1:0] i_addr_i;
  logic                 i_gnt_o;
  logic                 i_rvalid_o;
  logic                 i_err_o;
  logic [DataWidth-1:0] i_rdata_o;

  logic                 mem_ce_o;
  logic                 mem_we_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [DataWidth-1:0] mem_wdata_o;
  logic [DataWidth-1:0] mem_rdata_i;

  modport slave (
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_err_o, d_rdata_o,
    input  i_req_i, i_addr_i,
    output i_gnt_o, i_rvalid_o, i_err_o, i_rdata_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_err_o, d_rdata_o,
    output i_req_i, i_addr_i,
    input  i_gnt_o, i_rvalid_o, i_err_o, i_rdata_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Data/fetch arbiter onto one single-port sync RAM.
// Ports: clk_i, rst_i (async active-low), bus (mem_arbiter_if.slave).
module mem_arbiter #(
  parameter int                   DataWidth  = 32,
  parameter int                   AddrWidth  = 32,
  parameter logic [AddrWidth-1:0] MemBase    = 32'h0,
  parameter logic [AddrWidth-1:0] MemMask    = ~32'hFFFFF,
  parameter int                   MaxDataRun = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  mem_arbiter_if.slave  bus
);

  localparam int RunW = $clog2(MaxDataRun + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(MaxDataRun);
  localparam logic [AddrWidth-1:0] WinTag = MemBase & MemMask;

  logic [RunW-1:0] run_q, run_d;
  // {valid, host(1=fetch), err}
  logic [2:0]      resp_q, resp_d;
  logic            rwe_q, rwe_d;

  logic gnt_d, gnt_i;
  logic d_hit, i_hit;

  always_comb begin
    gnt_d = rst_i & bus.d_req_i
          & (~bus.i_req_i | (run_q != RunMax));
    gnt_i = rst_i & bus.i_req_i & ~gnt_d;
    d_hit = (bus.d_addr_i & MemMask) == WinTag;
    i_hit = (bus.i_addr_i & MemMask) == WinTag;
  end

  always_comb begin
    run_d = '0;
    if (gnt_d && bus.i_req_i)
      run_d = (run_q == RunMax) ? run_q : run_q + 1'b1;
  end

  always_comb begin
    bus.mem_ce_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    resp_d          = 3'b000;
    rwe_d           = 1'b0;
    unique case (1'b1)
      gnt_d: begin
        resp_d = {1'b1, 1'b0, ~d_hit};
        rwe_d  = bus.d_we_i;
        if (d_hit) begin
          bus.mem_ce_o    = 1'b1;
          bus.mem_we_o    = bus.d_we_i;
          bus.mem_addr_o  = bus.d_addr_i;
          bus.mem_wdata_o = bus.d_wdata_i;
        end
      end
      gnt_i: begin
        resp_d = {1'b1, 1'b1, ~i_hit};
        if (i_hit) begin
          bus.mem_ce_o   = 1'b1;
          bus.mem_addr_o = bus.i_addr_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_q  <= '0;
      resp_q <= 3'b000;
      rwe_q  <= 1'b0;
    end else begin
      run_q  <= run_d;
      resp_q <= resp_d;
      rwe_q  <= rwe_d;
    end
  end

  logic own_d, own_i, pass;

  always_comb begin
    own_d = resp_q[2] & ~resp_q[1];
    own_i = resp_q[2] &  resp_q[1];
    // Read data only for an in-range read.
    pass  = ~resp_q[0] & ~rwe_q;

    bus.d_gnt_o    = gnt_d;
    bus.i_gnt_o    = gnt_i;
    bus.d_rvalid_o = own_d;
    bus.d_err_o    = own_d & resp_q[0];
    bus.d_rdata_o  = (own_d & pass) ? bus.mem_rdata_i : '0;
    bus.i_rvalid_o = own_i;
    bus.i_err_o    = own_i & resp_q[0];
    bus.i_rdata_o  = (own_i & pass) ? bus.mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small sync RAM model.
// Checks grants, responses, errors, contention and reset.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_i;
  logic ram_ld;
  int   errs = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DataWidth(32), .AddrWidth(32)) bus ();

  mem_arbiter #(
    .DataWidth (32),
    .AddrWidth (32),
    .MemBase   (32'h0),
    .MemMask   (~32'hFFFFF),
    .MaxDataRun(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  logic [31:0] ram [256];

  always @(posedge clk) begin
    if (ram_ld) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h1000 + i;
      ram[64] <= 32'hDEADBEEF;
    end else if (bus.mem_ce_o) begin
      if (bus.mem_we_o)
        ram[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
      else
        bus.mem_rdata_i <= ram[bus.mem_addr_o[9:2]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ed;
    ram_ld          = 1'b1;
    rst_i           = 1'b0;
    bus.d_req_i     = 1'b1;
    bus.d_we_i      = 1'b0;
    bus.d_addr_i    = 32'h100;
    bus.d_wdata_i   = 32'h0;
    bus.i_req_i     = 1'b1;
    bus.i_addr_i    = 32'h0;
    tick();
    tick();
    ram_ld = 1'b0;
    chk("rst_d_gnt", 32'(bus.d_gnt_o), 32'd0);
    chk("rst_i_gnt", 32'(bus.i_gnt_o), 32'd0);
    chk("rst_ce", 32'(bus.mem_ce_o), 32'd0);
    chk("rst_d_rv", 32'(bus.d_rvalid_o), 32'd0);
    chk("rst_i_rv", 32'(bus.i_rvalid_o), 32'd0);
    chk("rst_d_rd", bus.d_rdata_o, 32'd0);

    rst_i = 1'b1;
    #1;
    chk("rel_d_gnt", 32'(bus.d_gnt_o), 32'd1);
    chk("rel_i_gnt", 32'(bus.i_gnt_o), 32'd0);
    chk("rd_ce", 32'(bus.mem_ce_o), 32'd1);
    chk("rd_addr", bus.mem_addr_o, 32'h100);
    tick();
    bus.d_req_i = 1'b0;
    bus.i_req_i = 1'b0;
    chk("rd_rv", 32'(bus.d_rvalid_o), 32'd1);
    chk("rd_data", bus.d_rdata_o, 32'hDEADBEEF);
    chk("rd_err", 32'(bus.d_err_o), 32'd0);
    chk("rd_i_rv", 32'(bus.i_rvalid_o), 32'd0);

    tick();
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 32'h20;
    bus.d_wdata_i = 32'h55AA;
    #1;
    chk("wr_gnt", 32'(bus.d_gnt_o), 32'd1);
    chk("wr_ce", 32'(bus.mem_ce_o), 32'd1);
    chk("wr_we", 32'(bus.mem_we_o), 32'd1);
    chk("wr_addr", bus.mem_addr_o, 32'h20);
    chk("wr_wdata", bus.mem_wdata_o, 32'h55AA);
    tick();
    bus.d_we_i    = 1'b0;
    bus.d_wdata_i = 32'h0;
    chk("wr_rv", 32'(bus.d_rvalid_o), 32'd1);
    chk("wr_rdata", bus.d_rdata_o, 32'd0);
    chk("wr_err", 32'(bus.d_err_o), 32'd0);
    tick();
    bus.d_req_i = 1'b0;
    chk("rb_rv", 32'(bus.d_rvalid_o), 32'd1);
    chk("rb_data", bus.d_rdata_o, 32'h55AA);

    bus.d_req_i  = 1'b1;
    bus.d_addr_i = 32'h100;
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 32'h20;
    for (int k = 0; k < 10; k++) begin
      ed = (k % 5) != 4;
      #1;
      chk($sformatf("ct_d_gnt%0d", k), 32'(bus.d_gnt_o), 32'(ed));
      chk($sformatf("ct_i_gnt%0d", k), 32'(bus.i_gnt_o), 32'(!ed));
      tick();
      chk($sformatf("ct_d_rv%0d", k), 32'(bus.d_rvalid_o), 32'(ed));
      chk($sformatf("ct_i_rv%0d", k), 32'(bus.i_rvalid_o), 32'(!ed));
      if (ed)
        chk($sformatf("ct_d_rd%0d", k), bus.d_rdata_o, 32'hDEADBEEF);
      else
        chk($sformatf("ct_i_rd%0d", k), bus.i_rdata_o, 32'h55AA);
    end
    bus.d_req_i = 1'b0;
    bus.i_req_i = 1'b0;
    tick();

    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 32'h200000;
    #1;
    chk("oor_gnt", 32'(bus.i_gnt_o), 32'd1);
    chk("oor_ce", 32'(bus.mem_ce_o), 32'd0);
    tick();
    bus.i_req_i = 1'b0;
    chk("oor_rv", 32'(bus.i_rvalid_o), 32'd1);
    chk("oor_err", 32'(bus.i_err_o), 32'd1);
    chk("oor_rd", bus.i_rdata_o, 32'd0);
    chk("oor_d_rv", 32'(bus.d_rvalid_o), 32'd0);

    tick();
    bus.d_req_i  = 1'b1;
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 32'h20;
    #1;
    chk("mr_gnt", 32'(bus.d_gnt_o), 32'd1);
    tick();
    rst_i       = 1'b0;
    bus.d_req_i = 1'b0;
    bus.i_req_i = 1'b0;
    #1;
    chk("mr_rv_low", 32'(bus.d_rvalid_o), 32'd0);
    tick();
    chk("mr_rv_hold", 32'(bus.d_rvalid_o), 32'd0);
    rst_i       = 1'b1;
    bus.d_req_i = 1'b1;
    bus.i_req_i = 1'b1;
    #1;
    chk("mr_rv_rel", 32'(bus.d_rvalid_o), 32'd0);
    chk("mr_irv_rel", 32'(bus.i_rvalid_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      ed = (k != 4);
      chk($sformatf("mr_d_gnt%0d", k), 32'(bus.d_gnt_o), 32'(ed));
      chk($sformatf("mr_i_gnt%0d", k), 32'(bus.i_gnt_o), 32'(!ed));
      tick();
      #1;
    end
    bus.d_req_i = 1'b0;
    bus.i_req_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-host, single-device memory arbiter between the core's data port and instruction-fetch port and one single-port synchronous RAM. Each cycle it grants at most one host. It forwards the granted request to the RAM and returns the response to the granted host one cycle later. Data accesses have priority, with a bounded-starvation guard for fetch. Addresses outside the RAM window are answered with an error and are not forwarded to the RAM.

## Interface
Parameters:
- DataWidth, 32, data bus width
- AddrWidth, 32, address bus width
- MemBase, 32'h0, RAM window base
- MemMask, ~32'hFFFFF, address bits that must match MemBase
- MaxDataRun, 4, consecutive data grants allowed while fetch waits (≥1)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- d_req_i  in  1  data request
- d_we_i  in  1  data write enable
- d_addr_i  in  AddrWidth  data address
- d_wdata_i  in  DataWidth  write data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data response valid
- d_err_o  out  1  data response error (qualified by d_rvalid_o)
- d_rdata_o  out  DataWidth  data read data
- i_req_i  in  1  fetch request (always read)
- i_addr_i  in  AddrWidth  fetch address
- i_gnt_o  out  1  fetch accepted this cycle
- i_rvalid_o  out  1  fetch response valid
- i_err_o  out  1  fetch response error
- i_rdata_o  out  DataWidth  fetch data
- mem_ce_o  out  1  RAM access strobe
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  AddrWidth  RAM address
- mem_wdata_o  out  DataWidth  RAM write data
- mem_rdata_i  in  DataWidth  RAM read data, valid the cycle after mem_ce_o

## Operation
- Grant logic is combinational from the *_req_i inputs and run_q.
  - Only one requester: that requester is granted.
  - Both request and run_q < MaxDataRun: data is granted.
  - Both request and run_q == MaxDataRun: fetch is granted.
- run_q, 0..MaxDataRun, saturating:
  - Data granted while i_req_i is high: run_q increments.
  - Fetch granted, or i_req_i low: run_q clears to 0.
- In-range test: (addr & MemMask) == (MemBase & MemMask).
- Granted and in range: mem_ce_o=1; mem_we_o, mem_addr_o and mem_wdata_o come from the granted host. Fetch always drives mem_we_o=0 and mem_wdata_o=0.
- Granted and out of range: mem_ce_o=0 and the response is an error.
- No grant: mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Response register resp_q = {valid, host, err}, loaded on every cycle from that cycle's grant.
- Response outputs, next cycle:
  - The owning host's *_rvalid_o=1 and *_err_o=resp_q.err.
  - rdata = mem_rdata_i for an in-range read; 0 for a write or an error.
  - The non-owning host's outputs are all 0.
- Writes produce an rvalid acknowledgement with rdata=0.
- Hosts must hold req/addr/we/wdata stable until gnt. The arbiter does not buffer requests.

## Timing
- Reset (rst_i low, asynchronous):
  - resp_q cleared and run_q=0.
  - All *_rvalid_o, *_err_o and *_rdata_o are 0.
  - *_gnt_o and mem_ce_o are forced to 0 while rst_i is low.
- Grant latency is 0 cycles. gnt asserts in the same cycle as req when the arbiter selects that host.
- Response latency is exactly 1 cycle after gnt, for hits and errors alike.
- Throughput is one access per cycle. Back-to-back grants to different hosts produce back-to-back rvalids in the same order.
- Reset asserted mid-access: a pending response is discarded and no rvalid is issued after reset release.
- Simultaneous req with run_q saturated: fetch wins, and data is granted the following cycle if still requesting.
- MaxDataRun=1 gives strict alternation under continuous contention.

## Test plan
- Reset: hold rst_i low with both reqs high -> all gnt, rvalid, mem_ce_o = 0. Release rst_i -> d_gnt_o=1 in the same cycle.
- Single data read at 0x100, RAM returning 0xDEADBEEF -> d_gnt_o=1 and mem_ce_o=1 at cycle t. At t+1: d_rvalid_o=1, d_rdata_o=0xDEADBEEF, d_err_o=0; i_rvalid_o=0.
- Data write 0x55AA to 0x20 -> mem_we_o=1, mem_wdata_o=0x55AA. Next cycle: d_rvalid_o=1, d_rdata_o=0.
- Continuous contention, MaxDataRun=4 -> grant pattern D,D,D,D,I repeating. Each rvalid goes to the matching host one cycle later.
- Fetch from 0x200000 (out of range) -> i_gnt_o=1, mem_ce_o=0. Next cycle: i_rvalid_o=1, i_err_o=1, i_rdata_o=0.
- rst_i pulsed low in the cycle after a data grant -> no d_rvalid_o is seen after release, and run_q restarts at 0.
